serial_addsub_framed: RTL and testbench
=======================================

Name: serial_addsub_framed

Overview:
Parametrised digit-serial adder/subtractor: accepts two operands least-significant digit first, DIGIT_W bits per cycle, framed into words of WORD_DIGITS digits. Carry propagates between digits in a register. Per-word add/subtract mode. Reports carry-out and signed overflow on the word's last digit. Successor to the 1-bit serial adder: used in bit/digit-serial datapaths where operand streams arrive over narrow links.

Parameters:
DIGIT_W, 1, bits processed per accepted digit (>=1)
WORD_DIGITS, 16, digits per word (>=1); word width = DIGIT_W*WORD_DIGITS

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  digit present on a/b this cycle
in_first  input  1  qualifies in_valid: digit is LS digit of a new word
sub  input  1  mode, sampled only with in_valid&in_first: 0 add (a+b), 1 subtract (a-b)
a  input  DIGIT_W  operand A digit
b  input  DIGIT_W  operand B digit
out_valid  output  1  out_digit valid
out_digit  output  DIGIT_W  result digit
out_last  output  1  out_digit is MS digit of the word
carry_out  output  1  final carry of word (sub: 1 = no borrow); 0 when out_last=0
overflow  output  1  two's-complement overflow of word; 0 when out_last=0
frame_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Reset (rst=0, async): state IDLE, digit counter 0, carry reg 0, mode reg 0; all outputs 0.
- States: IDLE (no word open), BUSY (word open, counter = digits accepted so far, 1..WORD_DIGITS-1).
- All outputs registered; latency 1 cycle from accepted digit to out_valid.
- in_valid=0: state, counter, carry, mode hold; next cycle out_valid=out_last=frame_err=carry_out=overflow=0; out_digit holds last value. Bubbles anywhere in a word are legal.
- Accepted digit (in_valid=1 & in_first=1, any state): cin = sub, m = sub, mode reg <= sub; counter restarts at this digit.
- Accepted digit (in_valid=1 & in_first=0 & BUSY): cin = carry reg, m = mode reg.
- Per digit: b_eff = m ? ~b : b; {c, s} = a + b_eff + cin (DIGIT_W+1 bits); out_digit <= s; carry reg <= c; out_valid <= 1.
- Last digit = digit index WORD_DIGITS-1 (WORD_DIGITS=1: every first digit is also last): out_last <= 1, carry_out <= c, overflow <= (carry into MSB of digit) XOR c; state -> IDLE, counter -> 0, carry reg -> 0. Otherwise state -> BUSY, counter +1.
- Counter width max(1, $clog2(WORD_DIGITS)); never exceeds WORD_DIGITS-1.
- Violation A, in_first while BUSY: previous word aborted (never gets out_last); frame_err <= 1; new digit processed normally as first digit.
- Violation B, in_valid & ~in_first while IDLE: digit dropped, out_valid <= 0, frame_err <= 1, state unchanged.
- Back-to-back words: in_first on the cycle after a last digit needs no bubble.
- Reset mid-word: word discarded, outputs clear immediately.

Test Plan:
- DIGIT_W=1, WORD_DIGITS=16, add a=0x4DB4, b=0x1D62 LSB first, no bubbles -> out_digit stream = 0x6B16, out_last on 16th output only, carry_out=0, overflow=0.
- DIGIT_W=4, WORD_DIGITS=4, sub a=0x4DB4, b=0x1D62 -> digits 2,5,0,3 (0x3052), carry_out=1, overflow=0. Then sub 0x0000-0x0001 -> 0xFFFF, carry_out=0, overflow=0.
- DIGIT_W=4, WORD_DIGITS=4, add 0x7FFF+0x0001 -> 0x8000, carry_out=0, overflow=1. Back-to-back add 0xFFFF+0x0001 -> 0x0000, carry_out=1, overflow=0; no bubble between words; second word gets no stale carry.
- Random in_valid bubbles (~50%) inside words, 200 random words both modes and both configurations -> results match the model for a +/- b mod 2^(DIGIT_W*WORD_DIGITS), plus carry_out and overflow.
- Framing: in_first after 2 of 4 digits -> frame_err pulse exactly 1 cycle, no out_last for the aborted word, new word correct. Digit with in_first=0 while IDLE -> out_valid stays 0, frame_err=1.
- rst asserted after 2 digits of a word -> all outputs 0 same cycle. Word started after release -> correct result; no residual carry.

Source files
------------

// File: rtl/serial_addsub_framed.sv
// Digit-serial adder/subtractor, LS digit first, framed into fixed-length words.
// Carry ripples between digits through a register; per-word add/sub mode.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   in_valid, in_first  digit strobe; first-digit-of-word qualifier
//   sub                 mode, sampled with in_first: 0 add, 1 subtract
//   a, b                operand digits (DIGIT_W bits)
//   out_valid           registered result digit strobe
//   out_digit           result digit (holds when out_valid=0)
//   out_last            result digit is the MS digit of its word
//   carry_out, overflow word carry (sub: 1 = no borrow) / signed overflow, on out_last only
//   frame_err           one-cycle pulse on a framing violation
module serial_addsub_framed #(
    parameter int DIGIT_W     = 1,
    parameter int WORD_DIGITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               sub,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] out_digit,
    output logic               out_last,
    output logic               carry_out,
    output logic               overflow,
    output logic               frame_err
);

    localparam int CW = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_DIGITS - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               mode_q, mode_d;
    logic               vld_q, vld_d;
    logic [DIGIT_W-1:0] dig_q, dig_d;
    logic               last_q, last_d;
    logic               co_q, co_d;
    logic               ov_q, ov_d;
    logic               fe_q, fe_d;

    logic               first_acc, cont_acc, stray;
    logic               cin, m;
    logic [CW-1:0]      idx;
    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W:0]   sum;
    logic               c_msb;

    assign first_acc = in_valid & in_first;
    assign cont_acc  = in_valid & ~in_first & (state_q == BUSY);
    assign stray     = in_valid & ~in_first & (state_q == IDLE);

    // A first digit restarts the word: its carry-in is the mode bit
    // (two's-complement +1 for subtract), otherwise the ripple carry.
    assign cin   = first_acc ? sub : carry_q;
    assign m     = first_acc ? sub : mode_q;
    assign idx   = first_acc ? '0 : cnt_q;
    assign b_eff = m ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};

    // Carry into the digit MSB, recovered from the sum bit and its inputs.
    assign c_msb = sum[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_eff[DIGIT_W-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        vld_d   = 1'b0;
        dig_d   = dig_q;
        last_d  = 1'b0;
        co_d    = 1'b0;
        ov_d    = 1'b0;
        fe_d    = 1'b0;
        if (first_acc) begin
            mode_d = sub;
            fe_d   = (state_q == BUSY);
        end
        if (stray) begin
            fe_d = 1'b1;
        end
        if (first_acc | cont_acc) begin
            vld_d = 1'b1;
            dig_d = sum[DIGIT_W-1:0];
            if (idx == LAST_IDX) begin
                last_d  = 1'b1;
                co_d    = sum[DIGIT_W];
                ov_d    = c_msb ^ sum[DIGIT_W];
                state_d = IDLE;
                cnt_d   = '0;
                carry_d = 1'b0;
            end else begin
                state_d = BUSY;
                cnt_d   = idx + CW'(1);
                carry_d = sum[DIGIT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            vld_q   <= 1'b0;
            dig_q   <= '0;
            last_q  <= 1'b0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            vld_q   <= vld_d;
            dig_q   <= dig_d;
            last_q  <= last_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            fe_q    <= fe_d;
        end
    end

    assign out_valid = vld_q;
    assign out_digit = dig_q;
    assign out_last  = last_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;
    assign frame_err = fe_q;

endmodule

// File: tb/tb_serial_addsub_framed.sv
// Bench for serial_addsub_framed: two instances (1x16 and 4x4 digits),
// word-level reference model checked every cycle plus literal word checks.
module tb_serial_addsub_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      vld, fst, sb;
    logic [1:0][3:0] av, bv;
    logic            o1_dig;
    logic [3:0]      o4_dig;
    logic [1:0]      o_vld, o_last, o_co, o_ov, o_fe;

    serial_addsub_framed #(.DIGIT_W(1), .WORD_DIGITS(16)) u_d1 (
        .clk(clk), .rst(rst),
        .in_valid(vld[0]), .in_first(fst[0]), .sub(sb[0]),
        .a(av[0][0:0]), .b(bv[0][0:0]),
        .out_valid(o_vld[0]), .out_digit(o1_dig), .out_last(o_last[0]),
        .carry_out(o_co[0]), .overflow(o_ov[0]), .frame_err(o_fe[0])
    );

    serial_addsub_framed #(.DIGIT_W(4), .WORD_DIGITS(4)) u_d4 (
        .clk(clk), .rst(rst),
        .in_valid(vld[1]), .in_first(fst[1]), .sub(sb[1]),
        .a(av[1]), .b(bv[1]),
        .out_valid(o_vld[1]), .out_digit(o4_dig), .out_last(o_last[1]),
        .carry_out(o_co[1]), .overflow(o_ov[1]), .frame_err(o_fe[1])
    );

    int nchk = 0;
    int nerr = 0;

    // Model: expected outputs after the next edge, and word-open flag.
    logic [1:0]      n_vld, n_last, n_co, n_ov, n_fe, open;
    logic [1:0][3:0] n_dig;
    logic [1:0]      c_vld, c_last, c_co, c_ov, c_fe;
    logic [1:0][3:0] c_dig;

    logic [15:0] asm_w [2];
    int          fe_cnt [2];
    logic [18:0] wq [$];

    function automatic int wd(int c);
        return (c != 0) ? 4 : 1;
    endfunction

    function automatic int nd(int c);
        return (c != 0) ? 4 : 16;
    endfunction

    function automatic logic [3:0] msk(int c);
        return (c != 0) ? 4'hF : 4'h1;
    endfunction

    // {carry_out, overflow, result} of a whole 16-bit word.
    function automatic logic [17:0] ref_word(logic [15:0] x, logic [15:0] y, bit s);
        logic [16:0] r;
        logic        co, ov;
        if (s) begin
            r  = {1'b0, x} - {1'b0, y};
            co = (x >= y);
            ov = (x[15] != y[15]) && (r[15] != x[15]);
        end else begin
            r  = {1'b0, x} + {1'b0, y};
            co = r[16];
            ov = (x[15] == y[15]) && (r[15] != x[15]);
        end
        return {co, ov, r[15:0]};
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic cmp(string nm, int c, logic [3:0] got, logic [3:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cfg%0d t=%0t: got %0h expected %0h", nm, c, $time, got, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [3:0] d;
        c_vld = n_vld; c_last = n_last; c_co = n_co;
        c_ov = n_ov; c_fe = n_fe; c_dig = n_dig;
        #1;
        for (int c = 0; c < 2; c++) begin
            d = (c != 0) ? o4_dig : {3'b000, o1_dig};
            cmp("out_valid", c, {3'b0, o_vld[c]}, {3'b0, c_vld[c]});
            cmp("out_digit", c, d, c_dig[c]);
            cmp("out_last", c, {3'b0, o_last[c]}, {3'b0, c_last[c]});
            cmp("carry_out", c, {3'b0, o_co[c]}, {3'b0, c_co[c]});
            cmp("overflow", c, {3'b0, o_ov[c]}, {3'b0, c_ov[c]});
            cmp("frame_err", c, {3'b0, o_fe[c]}, {3'b0, c_fe[c]});
            if (o_vld[c])
                asm_w[c] = (asm_w[c] >> wd(c)) | ({12'b0, d} << (16 - wd(c)));
            if (o_vld[c] && o_last[c])
                wq.push_back({c[0], o_co[c], o_ov[c], asm_w[c]});
            if (o_fe[c])
                fe_cnt[c]++;
        end
    end

    task automatic drive(int c, bit v, bit f, logic [15:0] x, logic [15:0] y, bit s, int idx);
        logic [17:0] r;
        logic [15:0] t;
        @(negedge clk);
        vld    = '0;
        vld[c] = v;
        fst[c] = f;
        sb[c]  = s;
        t = x >> (idx * wd(c));
        av[c] = t[3:0] & msk(c);
        t = y >> (idx * wd(c));
        bv[c] = t[3:0] & msk(c);
        n_vld = '0; n_last = '0; n_co = '0; n_ov = '0; n_fe = '0;
        if (v) begin
            if (f || open[c]) begin
                n_fe[c] = f && open[c];
                r = ref_word(x, y, s);
                t = r[15:0] >> (idx * wd(c));
                n_vld[c] = 1'b1;
                n_dig[c] = t[3:0] & msk(c);
                if (idx == nd(c) - 1) begin
                    n_last[c] = 1'b1;
                    n_co[c]   = r[17];
                    n_ov[c]   = r[16];
                    open[c]   = 1'b0;
                end else begin
                    open[c] = 1'b1;
                end
            end else begin
                n_fe[c] = 1'b1;
            end
        end
    endtask

    task automatic send(int c, logic [15:0] x, logic [15:0] y, bit s, int pct, int ndig);
        for (int i = 0; i < ndig; i++) begin
            while (int'($urandom_range(99)) < pct)
                drive(c, 0, 0, 16'($urandom), 16'($urandom), 0, 0);
            drive(c, 1, (i == 0), x, y, s, i);
        end
    endtask

    task automatic flush();
        repeat (2) drive(0, 0, 0, 16'h0, 16'h0, 0, 0);
    endtask

    task automatic expect_word(string nm, int c, logic [15:0] w, bit co, bit ov);
        logic [18:0] e;
        if (wq.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL %s: no word produced, expected %0h", nm, w);
        end else begin
            e = wq.pop_front();
            chk(nm, {13'b0, e}, {13'b0, c[0], co, ov, w});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        vld = '0;
        n_vld = '0; n_last = '0; n_co = '0; n_ov = '0; n_fe = '0;
        n_dig = '0; open = '0;
        #1;
        chk("rst_out_valid", {30'b0, o_vld}, 32'h0);
        chk("rst_out_digit", {27'b0, o4_dig, o1_dig}, 32'h0);
        chk("rst_flags", {22'b0, o_last, o_co, o_ov, o_fe}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int fe0;
        logic [15:0] x, y;
        bit s;
        rst = 1'b0;
        vld = '0; fst = '0; sb = '0; av = '0; bv = '0;
        n_vld = '0; n_last = '0; n_co = '0; n_ov = '0; n_fe = '0;
        n_dig = '0; open = '0;
        asm_w[0] = '0; asm_w[1] = '0;
        fe_cnt[0] = 0; fe_cnt[1] = 0;
        repeat (3) @(negedge clk);
        chk("reset_valid", {30'b0, o_vld}, 32'h0);
        chk("reset_digit", {27'b0, o4_dig, o1_dig}, 32'h0);
        chk("reset_flags", {22'b0, o_last, o_co, o_ov, o_fe}, 32'h0);
        rst = 1'b1;

        chk("model_add", {14'b0, ref_word(16'h4DB4, 16'h1D62, 0)}, {14'b0, 2'b00, 16'h6B16});
        chk("model_sub", {14'b0, ref_word(16'h4DB4, 16'h1D62, 1)}, {14'b0, 2'b10, 16'h3052});
        chk("model_0m1", {14'b0, ref_word(16'h0000, 16'h0001, 1)}, {14'b0, 2'b00, 16'hFFFF});
        chk("model_ovf", {14'b0, ref_word(16'h7FFF, 16'h0001, 0)}, {14'b0, 2'b01, 16'h8000});
        chk("model_wrap", {14'b0, ref_word(16'hFFFF, 16'h0001, 0)}, {14'b0, 2'b10, 16'h0000});

        send(0, 16'h4DB4, 16'h1D62, 0, 0, 16);
        flush();
        expect_word("w1_add", 0, 16'h6B16, 0, 0);

        send(1, 16'h4DB4, 16'h1D62, 1, 0, 4);
        send(1, 16'h0000, 16'h0001, 1, 0, 4);
        flush();
        expect_word("w4_sub", 1, 16'h3052, 1, 0);
        expect_word("w4_0m1", 1, 16'hFFFF, 0, 0);

        send(1, 16'h7FFF, 16'h0001, 0, 0, 4);
        send(1, 16'hFFFF, 16'h0001, 0, 0, 4);
        flush();
        expect_word("w4_ovf", 1, 16'h8000, 0, 1);
        expect_word("w4_wrap", 1, 16'h0000, 1, 0);

        fe0 = fe_cnt[1];
        send(1, 16'h1234, 16'h1111, 0, 0, 2);
        send(1, 16'h7FFF, 16'h0001, 0, 0, 4);
        flush();
        chk("abort_fe", 32'(fe_cnt[1] - fe0), 32'd1);
        chk("abort_words", 32'(wq.size()), 32'd1);
        expect_word("abort_new", 1, 16'h8000, 0, 1);

        fe0 = fe_cnt[1];
        drive(1, 1, 0, 16'h5555, 16'h3333, 0, 1);
        flush();
        chk("stray_fe", 32'(fe_cnt[1] - fe0), 32'd1);
        chk("stray_words", 32'(wq.size()), 32'd0);

        send(1, 16'hFFFF, 16'hFFFF, 0, 0, 2);
        do_reset();
        send(1, 16'h4DB4, 16'h1D62, 0, 0, 4);
        flush();
        chk("rst_words", 32'(wq.size()), 32'd1);
        expect_word("rst_new", 1, 16'h6B16, 0, 0);

        for (int k = 0; k < 200; k++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            s = 1'($urandom);
            send(k % 2, x, y, s, 50, nd(k % 2));
        end
        flush();
        chk("random_words", 32'(wq.size()), 32'd200);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
